// File: rtl/rs_syndrome_calc.sv
// Syndrome calculator for a Reed-Solomon decoder over GF(2^5), p(x) = x^5 + x^2 + 1.
// Evaluates S_j = r(alpha^j), j = 1..2T, by Horner's rule as the symbols stream in.
module rs_syndrome_calc #(
  parameter int N = 31,
  parameter int T = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [4:0]      sym_in,
  input  logic            sym_valid,
  output logic            sym_ready,
  output logic [10*T-1:0] synd_out,
  output logic            synd_valid,
  input  logic            synd_ready,
  output logic            err_detect
);

  localparam int NS = 2 * T;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      synd_q [NS];
  logic [4:0]      synd_d [NS];
  logic            err_q, err_d;
  logic            accept;
  logic            last_accept;

  // x * alpha: shift up one degree and fold alpha^5 back in as alpha^2 + 1.
  function automatic logic [4:0] mul_alpha(input logic [4:0] x);
    return {x[3:0], 1'b0} ^ (x[4] ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [4:0] mul_alpha_pow(input logic [4:0] x, input int j);
    logic [4:0] r;
    r = x;
    for (int i = 0; i < j; i++) r = mul_alpha(r);
    return r;
  endfunction

  assign accept      = sym_valid & sym_ready;
  assign last_accept = accept & (count_q == LAST_IDX);

  // NOTE: state uses non-blocking assignments only; all next values come from the _d combinational logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (last_accept) state_d = HOLD;
      HOLD:    if (synd_ready)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    sym_ready  = (state_q == ACCUM);
    synd_valid = (state_q == HOLD);
  end

  // sym_in is only looked at on an accept, so junk on an idle bus never reaches the registers.
  always_comb begin
    count_d = count_q;
    synd_d  = synd_q;
    err_d   = err_q;
    if (accept) begin
      count_d = last_accept ? '0 : count_q + 1'b1;
      for (int j = 0; j < NS; j++) begin
        synd_d[j] = (count_q == '0) ? sym_in
                                    : mul_alpha_pow(synd_q[j], j + 1) ^ sym_in;
      end
    end
    if (last_accept) begin
      err_d = 1'b0;
      for (int j = 0; j < NS; j++) err_d = err_d | (|synd_d[j]);
    end else if (state_q == HOLD && synd_ready) begin
      err_d = 1'b0;
    end
  end

  // NOTE: the syndrome array is a handful of flops, not a RAM, so it is reset; synd_out must read zero after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int j = 0; j < NS; j++) synd_q[j] <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      for (int j = 0; j < NS; j++) synd_q[j] <= synd_d[j];
    end
  end

  always_comb begin
    synd_out = '0;
    for (int j = 0; j < NS; j++) synd_out[5*j +: 5] = synd_q[j];
  end

  assign err_detect = err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: table of codewords, scoreboard of expected
// syndrome sets, plus hand-written hold/backpressure and mid-codeword reset sequences.
module tb_rs_syndrome_calc;

  localparam int N  = 31;
  localparam int T  = 2;
  localparam int SW = 10 * T;

  logic          clock;
  logic          reset_n;
  logic [4:0]    sym_in;
  logic          sym_valid;
  logic          sym_ready;
  logic [SW-1:0] synd_out;
  logic          synd_valid;
  logic          synd_ready;
  logic          err_detect;

  rs_syndrome_calc #(.N(N), .T(T)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .synd_out   (synd_out),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .err_detect (err_detect)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef logic [4:0] cw_t [N];

  typedef struct {
    string         name;
    int            pos0;
    logic [4:0]    val0;
    int            pos1;
    logic [4:0]    val1;
    bit            rnd;
    bit            gaps;
    bit            use_exp;
    logic [SW-1:0] exp_synd;
    bit            exp_err;
  } vec_t;

  typedef struct {
    string         name;
    logic [SW-1:0] synd;
    logic          err;
  } sb_t;

  sb_t sb [$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference arithmetic: full polynomial multiply then reduce, and syndromes as a
  // direct power sum over every coefficient.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [8:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (9'(a) << i);
    for (int k = 8; k >= 5; k--) if (p[k]) p = p ^ (9'(6'b100101) << (k - 5));
    return p[4:0];
  endfunction

  function automatic logic [4:0] alpha_pow(input int e);
    logic [4:0] r;
    r = 5'h01;
    for (int i = 0; i < (e % 31); i++) r = gf_mul(r, 5'h02);
    return r;
  endfunction

  task automatic model(input cw_t cw, output logic [SW-1:0] synd, output logic err);
    logic [4:0] s;
    synd = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      s = '0;
      for (int k = 0; k < N; k++) s = s ^ gf_mul(cw[k], alpha_pow(j * (N - 1 - k)));
      synd[5*(j-1) +: 5] = s;
    end
    err = |synd;
  endtask

  function automatic vec_t mk(input string name, input int p0, input logic [4:0] v0,
                              input int p1, input logic [4:0] v1, input bit rnd,
                              input bit gaps, input bit use_exp,
                              input logic [SW-1:0] es, input bit ee);
    vec_t v;
    v.name = name; v.pos0 = p0; v.val0 = v0; v.pos1 = p1; v.val1 = v1;
    v.rnd = rnd; v.gaps = gaps; v.use_exp = use_exp; v.exp_synd = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic build(input vec_t v, output cw_t cw);
    for (int k = 0; k < N; k++) cw[k] = v.rnd ? 5'($urandom) : 5'h00;
    if (v.pos0 >= 0) cw[v.pos0] = v.val0;
    if (v.pos1 >= 0) cw[v.pos1] = v.val1;
  endtask

  task automatic push_exp(input string name, input cw_t cw, input vec_t v);
    sb_t e;
    logic [SW-1:0] ms;
    logic          me;
    model(cw, ms, me);
    e.name = name;
    e.synd = v.use_exp ? v.exp_synd : ms;
    e.err  = v.use_exp ? v.exp_err  : me;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int b;
    b = 0;
    while (!sym_ready && b < 50) begin
      @(posedge clock); #1;
      b++;
    end
    if (!sym_ready) check({name, "_ready_timeout"}, 32'(sym_ready), 32'd1);
  endtask

  task automatic send(input string name, input cw_t cw, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        sym_valid = 1'b0;
        sym_in    = 5'($urandom);
        @(posedge clock); #1;
      end
      sym_valid = 1'b1;
      sym_in    = cw[i];
      wait_ready(name);
      if (i == N - 1) check({name, "_valid_before_last"}, 32'(synd_valid), 32'd0);
      @(posedge clock); #1;
    end
    sym_valid = 1'b0;
    sym_in    = 5'($urandom);
    check({name, "_latency"}, 32'(synd_valid), 32'd1);
  endtask

  // Scoreboard side: compare whenever the downstream handshake is about to complete.
  always @(negedge clock) begin
    if (reset_n && synd_valid && synd_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check({e.name, "_synd"}, 32'(synd_out), 32'(e.synd));
        check({e.name, "_err"}, 32'(err_detect), 32'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs [7];

  initial begin
    cw_t           cw;
    vec_t          v;
    logic [SW-1:0] hold_exp;

    vecs[0] = mk("all_zero",   -1, 5'h00, -1, 5'h00, 0, 0, 1, 20'h0, 0);
    vecs[1] = mk("r_is_one",   30, 5'h01, -1, 5'h00, 0, 0, 1, {4{5'h01}}, 1);
    vecs[2] = mk("r_is_x30",    0, 5'h01, -1, 5'h00, 0, 0, 1, {5'h0b, 5'h16, 5'h09, 5'h12}, 1);
    vecs[3] = mk("x30_gaps",    0, 5'h01, -1, 5'h00, 0, 1, 1, {5'h0b, 5'h16, 5'h09, 5'h12}, 1);
    vecs[4] = mk("one_err",    10, 5'h07, -1, 5'h00, 0, 0, 0, 20'h0, 0);
    vecs[5] = mk("two_err",     3, 5'h1f, 25, 5'h0a, 0, 1, 0, 20'h0, 0);
    vecs[6] = mk("random",     -1, 5'h00, -1, 5'h00, 1, 0, 0, 20'h0, 0);

    reset_n    = 1'b0;
    sym_valid  = 1'b0;
    sym_in     = 5'h00;
    synd_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_sym_ready",  32'(sym_ready),  32'd1);
    check("reset_synd_valid", 32'(synd_valid), 32'd0);
    check("reset_err",        32'(err_detect), 32'd0);
    check("reset_synd_out",   32'(synd_out),   32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      build(v, cw);
      push_exp(v.name, cw, v);
      send(v.name, cw, v.gaps);
    end

    // Backpressure: syndromes must hold while offered symbols are refused.
    @(posedge clock); #1;
    synd_ready = 1'b0;
    v = vecs[2];
    build(v, cw);
    push_exp("hold", cw, v);
    hold_exp = v.exp_synd;
    send("hold", cw, 1'b0);
    sym_valid = 1'b1;
    sym_in    = 5'h1f;
    for (int c = 0; c < 5; c++) begin
      check("hold_sym_ready",  32'(sym_ready),  32'd0);
      check("hold_synd_valid", 32'(synd_valid), 32'd1);
      check("hold_synd_out",   32'(synd_out),   32'(hold_exp));
      @(posedge clock); #1;
    end
    sym_valid  = 1'b0;
    synd_ready = 1'b1;
    @(posedge clock); #1;
    check("release_sym_ready",  32'(sym_ready),  32'd1);
    check("release_synd_valid", 32'(synd_valid), 32'd0);
    check("release_synd_kept",  32'(synd_out),   32'(hold_exp));
    v = vecs[5];
    build(v, cw);
    push_exp("after_hold", cw, v);
    send("after_hold", cw, 1'b0);

    // Mid-codeword asynchronous reset, then a clean all-zero codeword.
    @(posedge clock); #1;
    for (int i = 0; i < 15; i++) begin
      sym_valid = 1'b1;
      sym_in    = 5'h1f;
      wait_ready("pre_reset");
      @(posedge clock); #1;
    end
    check("pre_reset_nonzero", 32'(synd_out != '0), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_synd_out",   32'(synd_out),   32'd0);
    check("async_sym_ready",  32'(sym_ready),  32'd1);
    check("async_synd_valid", 32'(synd_valid), 32'd0);
    check("async_err",        32'(err_detect), 32'd0);
    sym_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    v = vecs[0];
    build(v, cw);
    push_exp("post_reset_zero", cw, v);
    send("post_reset_zero", cw, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
